// File: rtl/maverickOne_pkg.sv
// maverickOne_pkg: shared register-file sizing and vector typedefs
package maverickOne_pkg;
    localparam int NUM_REGS = 64;
    typedef logic [NUM_REGS-1:0] reg_vec_t;
    typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;
endpackage

// File: rtl/reg_grant_checker_if.sv
// reg_grant_checker_if: per-slot hazard-check bundle between issue logic and checker
interface reg_grant_checker_if
    import maverickOne_pkg::*;
#(
    parameter int NR    = NUM_REGS,
    parameter int CNT_W = 16
);
    logic                  pl_valid_i;
    logic                  blocking_i;
    logic [$clog2(NR)-1:0] rd_i;
    logic [NR-1:0]         reg_req_i;
    logic [NR-1:0]         locks_i;
    logic                  mem_op_i;
    logic                  mem_busy_i;
    logic [NR-1:0]         locks_o;
    logic                  arb_req_o;
    logic                  mem_busy_o;
    logic [CNT_W-1:0]      stall_cnt_o;

    modport master (
        output pl_valid_i, blocking_i, rd_i, reg_req_i, locks_i, mem_op_i, mem_busy_i,
        input  locks_o, arb_req_o, mem_busy_o, stall_cnt_o
    );

    modport slave (
        input  pl_valid_i, blocking_i, rd_i, reg_req_i, locks_i, mem_op_i, mem_busy_i,
        output locks_o, arb_req_o, mem_busy_o, stall_cnt_o
    );
endinterface

// File: rtl/reg_grant_checker_reg_idx_decoder.sv
// reg_idx_decoder: destination index to one-hot lock bit; x0 never gets locked
module reg_idx_decoder
    import maverickOne_pkg::*;
#(
    parameter int NR = NUM_REGS
) (
    input  logic [$clog2(NR)-1:0] idx_i,
    output logic [NR-1:0]         onehot_o
);
    localparam logic [NR-1:0] ONE = {{(NR-1){1'b0}}, 1'b1};

    assign onehot_o = (ONE << idx_i) & ~ONE;
endmodule

// File: rtl/reg_grant_checker.sv
// reg_grant_checker: register/memory hazard gate for one issue slot, with stall counter
module reg_grant_checker
    import maverickOne_pkg::*;
#(
    parameter int NR    = NUM_REGS,
    parameter int CNT_W = 16
) (
    input logic                clk_i,
    input logic                arst_ni,
    reg_grant_checker_if.slave bus
);
    logic [NR-1:0]    w_rd_onehot;
    logic             w_reg_hazard;
    logic             w_mem_hazard;
    logic             w_arb_req;
    logic             w_stall;
    logic [CNT_W-1:0] r_stall_cnt;

    reg_idx_decoder #(.NR(NR)) u_dec (
        .idx_i    (bus.rd_i),
        .onehot_o (w_rd_onehot)
    );

    assign w_reg_hazard = |(bus.reg_req_i & bus.locks_i);
    assign w_mem_hazard = bus.mem_op_i & bus.mem_busy_i;
    assign w_arb_req    = bus.pl_valid_i & ~w_reg_hazard & ~w_mem_hazard;
    assign w_stall      = bus.pl_valid_i & ~w_arb_req;

    // Downstream lock view: destination is reserved even if this slot stalls
    always_comb begin
        bus.locks_o    = !bus.pl_valid_i ? bus.locks_i :
                         bus.blocking_i  ? '1 : (bus.locks_i | w_rd_onehot);
        bus.mem_busy_o = bus.mem_busy_i | (bus.pl_valid_i & bus.mem_op_i);
        bus.arb_req_o  = w_arb_req;
    end

    // Saturating count of valid cycles that could not request arbitration
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni)
            r_stall_cnt <= '0;
        else if (w_stall && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign bus.stall_cnt_o = r_stall_cnt;
endmodule

// File: tb/tb_reg_grant_checker.sv
// tb_reg_grant_checker: directed checks of hazard gating, lock update and stall counter
module tb_reg_grant_checker;
    import maverickOne_pkg::*;

    logic clk_i = 1'b0;
    logic arst_ni = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk_i = ~clk_i;

    reg_grant_checker_if #(.NR(NUM_REGS), .CNT_W(16)) a ();
    reg_grant_checker_if #(.NR(NUM_REGS), .CNT_W(2))  b ();

    reg_grant_checker #(.NR(NUM_REGS), .CNT_W(16)) dut_a (.clk_i(clk_i), .arst_ni(arst_ni), .bus(a.slave));
    reg_grant_checker #(.NR(NUM_REGS), .CNT_W(2))  dut_b (.clk_i(clk_i), .arst_ni(arst_ni), .bus(b.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic blk, input reg_idx_t rd, input reg_vec_t req,
                           input reg_vec_t lk, input logic mo, input logic mb);
        @(negedge clk_i);
        a.pl_valid_i = v;  a.blocking_i = blk; a.rd_i = rd; a.reg_req_i = req;
        a.locks_i = lk;    a.mem_op_i = mo;    a.mem_busy_i = mb;
        #1;
    endtask

    task automatic edge_chk(input string tag, input logic [63:0] exp_cnt);
        @(posedge clk_i);
        #1;
        chk(tag, 64'(a.stall_cnt_o), exp_cnt);
    endtask

    reg_vec_t e_locks;
    logic     e_arb;
    logic     e_mb;
    int       e_cnt;

    initial begin
        a.pl_valid_i = 0; a.blocking_i = 0; a.rd_i = '0; a.reg_req_i = '0;
        a.locks_i = '0;   a.mem_op_i = 0;   a.mem_busy_i = 0;
        b.pl_valid_i = 0; b.blocking_i = 0; b.rd_i = '0; b.reg_req_i = '0;
        b.locks_i = '0;   b.mem_op_i = 0;   b.mem_busy_i = 0;
        #1 arst_ni = 1'b0;
        #1;
        chk("reset_cnt_a", 64'(a.stall_cnt_o), 64'd0);
        chk("reset_cnt_b", 64'(b.stall_cnt_o), 64'd0);
        @(negedge clk_i);
        arst_ni = 1'b1;

        drive_a(0, 0, 6'd0, 64'h3, 64'h0, 0, 1);
        chk("idle_arb", 64'(a.arb_req_o), 64'd0);
        chk("idle_locks", a.locks_o, 64'h0);
        chk("idle_mb", 64'(a.mem_busy_o), 64'd1);
        edge_chk("idle_cnt", 64'd0);

        drive_a(1, 0, 6'd5, 64'h0C, 64'h10, 0, 0);
        chk("free_arb", 64'(a.arb_req_o), 64'd1);
        chk("free_locks", a.locks_o, 64'h30);
        chk("free_mb", 64'(a.mem_busy_o), 64'd0);
        edge_chk("free_cnt", 64'd0);

        drive_a(1, 0, 6'd5, 64'h0C, 64'h08, 0, 0);
        chk("hazard_arb", 64'(a.arb_req_o), 64'd0);
        chk("hazard_locks", a.locks_o, 64'h28);
        edge_chk("hazard_cnt", 64'd1);

        drive_a(1, 1, 6'd0, 64'h0C, 64'h0, 0, 0);
        chk("block_locks", a.locks_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("block_arb", 64'(a.arb_req_o), 64'd1);
        edge_chk("block_cnt", 64'd1);

        drive_a(1, 0, 6'd0, 64'h0, 64'h5, 0, 0);
        chk("rd0_locks", a.locks_o, 64'h5);
        chk("rd0_arb", 64'(a.arb_req_o), 64'd1);

        drive_a(1, 0, 6'd3, 64'h1, 64'h1, 0, 0);
        chk("x0_arb", 64'(a.arb_req_o), 64'd0);
        chk("x0_locks", a.locks_o, 64'h9);
        edge_chk("x0_cnt", 64'd2);

        drive_a(1, 0, 6'd63, 64'h0, 64'h0, 1, 1);
        chk("membusy_arb", 64'(a.arb_req_o), 64'd0);
        chk("membusy_mb", 64'(a.mem_busy_o), 64'd1);
        chk("rd63_locks", a.locks_o, 64'h8000_0000_0000_0000);
        edge_chk("membusy_cnt", 64'd3);

        drive_a(1, 0, 6'd0, 64'h0, 64'h0, 1, 0);
        chk("memop_arb", 64'(a.arb_req_o), 64'd1);
        chk("memop_mb", 64'(a.mem_busy_o), 64'd1);
        edge_chk("memop_cnt", 64'd3);

        drive_a(0, 1, 6'd7, 64'h0, 64'hA, 1, 0);
        chk("inv_locks", a.locks_o, 64'hA);
        chk("inv_mb", 64'(a.mem_busy_o), 64'd0);
        chk("inv_arb", 64'(a.arb_req_o), 64'd0);

        @(negedge clk_i);
        b.pl_valid_i = 1; b.reg_req_i = 64'h1; b.locks_i = 64'h1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            chk("sat_cnt", 64'(b.stall_cnt_o), (i < 3) ? 64'(i + 1) : 64'd3);
        end
        #2 arst_ni = 1'b0;
        #1;
        chk("async_rst_b", 64'(b.stall_cnt_o), 64'd0);
        chk("async_rst_a", 64'(a.stall_cnt_o), 64'd0);
        chk("rst_comb_arb", 64'(b.arb_req_o), 64'd0);
        chk("rst_comb_locks", b.locks_o, 64'h1);
        @(negedge clk_i);
        arst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post_rst_b", 64'(b.stall_cnt_o), 64'd1);

        e_cnt = int'(a.stall_cnt_o);
        for (int i = 0; i < 300; i++) begin
            drive_a(1'($urandom), 1'($urandom_range(0, 3) == 0), 6'($urandom_range(0, 63)),
                    {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom},
                    {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom},
                    1'($urandom), 1'($urandom));
            e_arb   = a.pl_valid_i & ~|(a.reg_req_i & a.locks_i) & ~(a.mem_op_i & a.mem_busy_i);
            e_mb    = a.mem_busy_i | (a.pl_valid_i & a.mem_op_i);
            e_locks = !a.pl_valid_i ? a.locks_i : a.blocking_i ? '1 :
                      (a.rd_i == 0) ? a.locks_i : (a.locks_i | (64'd1 << a.rd_i));
            chk("rnd_arb", 64'(a.arb_req_o), 64'(e_arb));
            chk("rnd_mb", 64'(a.mem_busy_o), 64'(e_mb));
            chk("rnd_locks", a.locks_o, e_locks);
            if (a.pl_valid_i && !e_arb && e_cnt < 65535) e_cnt++;
            edge_chk("rnd_cnt", 64'(e_cnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
